// File: rtl/vram_arbiter_pkg.sv
// Shared VRAM arbiter definitions: bus widths, read latency,
// master identifiers and lock-FSM state encoding.
package vram_arbiter_pkg;

    localparam int VRAM_ADDR_W = 11;
    localparam int VRAM_DATA_W = 9;
    localparam int VRAM_RD_LAT = 1;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_st_e;

    function automatic logic [1:0] onehot(input master_e m);
        return (m == M1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// One master's request/response channel into the VRAM arbiter.
// master: drives valid/addr/wdata/we/lock; slave: drives ready/rvalid/rdata.
interface vram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 9
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              lock;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, addr, wdata, we, lock,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wdata, we, lock,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/vram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with lock override, one-hot grant.
// i_req: {m1,m0} requests; i_last: last granted; i_locked/i_owner: lock; o_gnt: grant.
module vram_arbiter_rr_arb2
    import vram_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  master_e    i_last,
    input  logic       i_locked,
    input  master_e    i_owner,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        if (i_locked) begin
            // Owner only; the other master waits even if owner idles.
            o_gnt = i_req & onehot(i_owner);
        end else begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = (i_last == M0) ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Shares the single VRAM port between M0 and M1: round-robin, lock for RMW,
// registered issue stage and tagged read return.
// Ports: i_clk/i_rst, m0/m1 slave channels, o_vram_* / i_vram_dout VRAM port.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W   = VRAM_ADDR_W,
    parameter int DATA_W   = VRAM_DATA_W,
    parameter int MAX_LOCK = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    vram_arbiter_if.slave     m0,
    vram_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [DATA_W-1:0] o_vram_din,
    input  logic [DATA_W-1:0] i_vram_dout,
    output logic              o_vram_clk,
    output logic              o_vram_ce,
    output logic              o_vram_wre
);

    // Counter holds 0..MAX_LOCK-1; timeout fires on the last locked cycle.
    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

    lock_st_e          r_state, w_state_nxt;
    master_e           r_owner, w_owner_nxt;
    master_e           r_last,  w_last_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;

    logic [1:0]        w_gnt;
    logic [1:0]        w_rdy;
    logic              w_xfer;
    master_e           w_win;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_we;
    logic              w_lock;
    logic              w_timeout;
    logic              w_sat;

    logic              r_ce;
    logic              r_wre;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;
    logic              r_rd1_v;
    master_e           r_rd1_id;
    logic              r_rd2_v;
    master_e           r_rd2_id;

    vram_arbiter_rr_arb2 u_arb (
        .i_req    ({m1.valid, m0.valid}),
        .i_last   (r_last),
        .i_locked (r_state == ST_LOCKED),
        .i_owner  (r_owner),
        .o_gnt    (w_gnt)
    );

    // No accepts while reset is held so outputs stay quiet.
    assign w_rdy   = w_gnt & {2{~i_rst}};
    assign w_xfer  = |w_rdy;
    assign w_win   = w_rdy[1] ? M1 : M0;
    assign w_addr  = w_rdy[1] ? m1.addr  : m0.addr;
    assign w_wdata = w_rdy[1] ? m1.wdata : m0.wdata;
    assign w_we    = w_rdy[1] ? m1.we    : m0.we;
    assign w_lock  = w_rdy[1] ? m1.lock  : m0.lock;

    assign m0.ready = w_rdy[0];
    assign m1.ready = w_rdy[1];

    assign w_sat     = &r_cnt;
    assign w_timeout = (r_state == ST_LOCKED) && (MAX_LOCK != 0)
                    && (r_cnt == CNT_W'(MAX_LOCK - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        if (w_xfer) w_last_nxt = w_win;
        unique case (r_state)
            ST_UNLOCKED: begin
                if (w_xfer && w_lock) begin
                    w_state_nxt = ST_LOCKED;
                    w_owner_nxt = w_win;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOCKED: begin
                if (!w_sat) w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_timeout) begin
                    // Hand the next contention to the other master.
                    w_state_nxt = ST_UNLOCKED;
                    w_last_nxt  = r_owner;
                    w_cnt_nxt   = '0;
                end else if (w_xfer && !w_lock) begin
                    w_state_nxt = ST_UNLOCKED;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_UNLOCKED;
            r_owner <= M0;
            r_last  <= M1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Issue register, then two tag stages: ce cycle, dout cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ce     <= 1'b0;
            r_wre    <= 1'b0;
            r_addr   <= '0;
            r_din    <= '0;
            r_rd1_v  <= 1'b0;
            r_rd1_id <= M0;
            r_rd2_v  <= 1'b0;
            r_rd2_id <= M0;
        end else begin
            r_ce    <= w_xfer;
            r_wre   <= w_xfer & w_we;
            if (w_xfer) begin
                r_addr <= w_addr;
                r_din  <= w_wdata;
            end
            r_rd1_v  <= w_xfer & ~w_we;
            r_rd1_id <= w_win;
            r_rd2_v  <= r_rd1_v;
            r_rd2_id <= r_rd1_id;
        end
    end

    assign m0.rvalid = r_rd2_v && (r_rd2_id == M0);
    assign m1.rvalid = r_rd2_v && (r_rd2_id == M1);
    assign m0.rdata  = m0.rvalid ? i_vram_dout : '0;
    assign m1.rdata  = m1.rvalid ? i_vram_dout : '0;

    assign o_vram_clk  = i_clk;
    assign o_vram_ce   = r_ce;
    assign o_vram_wre  = r_wre;
    assign o_vram_addr = r_addr;
    assign o_vram_din  = r_din;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and random checks of vram_arbiter against a behavioural
// model of arbitration, locking and VRAM contents.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int AW   = VRAM_ADDR_W;
    localparam int DW   = VRAM_DATA_W;
    localparam int MAXL = 8;
    localparam int NRND = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_din;
    logic [DW-1:0] vram_dout;
    logic          vram_clk;
    logic          vram_ce;
    logic          vram_wre;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAXL)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .m0          (m0_if),
        .m1          (m1_if),
        .o_vram_addr (vram_addr),
        .o_vram_din  (vram_din),
        .i_vram_dout (vram_dout),
        .o_vram_clk  (vram_clk),
        .o_vram_ce   (vram_ce),
        .o_vram_wre  (vram_wre)
    );

    // Write-first VRAM, one cycle read latency.
    logic [DW-1:0] vmem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (vram_ce) begin
            if (vram_wre) begin
                vmem[vram_addr] <= vram_din;
                vram_dout       <= vram_din;
            end else begin
                vram_dout <= vmem[vram_addr];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int m, input logic v, input logic we,
                       input logic lk, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        if (m == 0) begin
            m0_if.valid = v; m0_if.we = we; m0_if.lock = lk;
            m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.valid = v; m1_if.we = we; m1_if.lock = lk;
            m1_if.addr = a; m1_if.wdata = d;
        end
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, '0, '0);
        drv(1, 0, 0, 0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rdy(input string tag, input logic e0, input logic e1);
        chk({tag, "_r0"}, m0_if.ready, e0);
        chk({tag, "_r1"}, m1_if.ready, e1);
    endtask

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           q[$];
    rd_t           r;
    logic [DW-1:0] mmem [0:15];
    int            m_lock, m_owner, m_last, m_held, cyc, eg;
    bit            p_x, p_we;
    logic [AW-1:0] p_a;
    logic [DW-1:0] p_d;
    bit            v[2], we[2], lk[2];
    logic [AW-1:0] a[2];
    logic [DW-1:0] d[2];

    initial begin
        idle();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_ce", vram_ce, 0);
        chk("rst_wre", vram_wre, 0);
        chk("rst_addr", vram_addr, 0);
        chk("rst_din", vram_din, 0);
        chk("rst_rv0", m0_if.rvalid, 0);
        chk("rst_rv1", m1_if.rvalid, 0);
        chk("vclk", vram_clk, clk);
        rdy("rst", 0, 0);
        step();

        // 1: write then read back
        drv(0, 1, 1, 0, 11'h025, 9'h041);
        @(negedge clk); rdy("t1w", 1, 0);
        step();
        drv(0, 1, 0, 0, 11'h025, 9'h000);
        @(negedge clk); rdy("t1r", 1, 0);
        chk("t1_ce", vram_ce, 1);
        chk("t1_wre", vram_wre, 1);
        chk("t1_addr", vram_addr, 11'h025);
        chk("t1_din", vram_din, 9'h041);
        step();
        idle();
        @(negedge clk);
        chk("t1_ce2", vram_ce, 1);
        chk("t1_wre2", vram_wre, 0);
        chk("t1_norv", m0_if.rvalid, 0);
        step();
        @(negedge clk);
        chk("t1_rv0", m0_if.rvalid, 1);
        chk("t1_rd0", m0_if.rdata, 9'h041);
        chk("t1_rv1", m1_if.rvalid, 0);
        chk("t1_ce3", vram_ce, 0);
        step();
        @(negedge clk);
        chk("t1_rv0_off", m0_if.rvalid, 0);

        // 2: alternation from reset
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drv(0, 1, 0, 0, 11'(11'h200 + i), '0);
            drv(1, 1, 0, 0, 11'(11'h280 + i), '0);
            @(negedge clk);
            rdy($sformatf("t2_%0d", i), i % 2 == 0, i % 2 == 1);
            step();
        end
        idle();
        repeat (3) step();

        // 3: lock, release, other master next cycle
        drv(0, 1, 1, 0, 11'h040, 9'h155);
        @(negedge clk); rdy("t3pre", 1, 0);
        step();
        drv(0, 1, 0, 0, 11'h300, '0);
        drv(1, 1, 0, 1, 11'h040, '0);
        @(negedge clk); rdy("t3a", 0, 1);
        step();
        drv(1, 1, 1, 0, 11'h000, 9'h0AA);
        @(negedge clk); rdy("t3b", 0, 1);
        step();
        drv(1, 0, 0, 0, '0, '0);
        @(negedge clk); rdy("t3c", 1, 0);
        chk("t3_rv1", m1_if.rvalid, 1);
        chk("t3_rd1", m1_if.rdata, 9'h155);
        step();
        idle();
        repeat (3) step();

        // Owner idle while locked: no preemption
        drv(1, 1, 1, 1, 11'h101, 9'h003);
        @(negedge clk); rdy("np0", 0, 1);
        step();
        drv(1, 0, 0, 0, '0, '0);
        drv(0, 1, 0, 0, 11'h301, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); rdy($sformatf("np_blk%0d", i), 0, 0);
            step();
        end
        drv(1, 1, 1, 0, 11'h102, 9'h004);
        @(negedge clk); rdy("np_rel", 0, 1);
        step();
        drv(1, 0, 0, 0, '0, '0);
        @(negedge clk); rdy("np_go", 1, 0);
        step();
        idle();
        repeat (3) step();

        // 4: lock timeout after MAXL locked cycles
        drv(0, 1, 0, 0, 11'h302, '0);
        drv(1, 1, 1, 1, 11'h110, 9'h005);
        for (int i = 0; i <= MAXL; i++) begin
            @(negedge clk); rdy($sformatf("t4_%0d", i), 0, 1);
            step();
        end
        @(negedge clk); rdy("t4_to", 1, 0);
        step();
        idle();
        repeat (3) step();

        // 5: reset during back-to-back reads
        do_reset();
        drv(0, 1, 0, 0, 11'h025, '0);
        @(negedge clk); rdy("t5a", 1, 0);
        step();
        drv(0, 1, 0, 0, 11'h040, '0);
        @(negedge clk); rdy("t5b", 1, 0);
        step();
        rst = 1'b1;
        drv(0, 1, 0, 0, 11'h000, '0);
        @(negedge clk); rdy("t5rst", 0, 0);
        step();
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk("t5_ce", vram_ce, 0);
        chk("t5_addr", vram_addr, 0);
        chk("t5_din", vram_din, 0);
        chk("t5_wre", vram_wre, 0);
        chk("t5_rv0", m0_if.rvalid, 0);
        chk("t5_rd0", m0_if.rdata, 0);
        chk("t5_rv1", m1_if.rvalid, 0);
        step();
        drv(0, 1, 0, 0, 11'h025, '0);
        drv(1, 1, 0, 0, 11'h040, '0);
        @(negedge clk);
        chk("t5_rv0b", m0_if.rvalid, 0);
        rdy("t5new", 1, 0);
        step();
        idle();
        repeat (3) step();

        // 6: random traffic against the model
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drv(0, 1, 1, 0, 11'(11'h7F0 + i), 9'(i * 37 + 5));
            mmem[i] = 9'(i * 37 + 5);
            @(negedge clk); rdy("pre", 1, 0);
            step();
        end
        idle();
        step();
        step();
        m_lock = 0; m_owner = 0; m_last = 0; m_held = 0;
        cyc = 0; p_x = 0; p_we = 0; p_a = '0; p_d = '0;
        for (int i = 0; i < NRND; i++) begin
            for (int m = 0; m < 2; m++) begin
                v[m]  = (i < NRND - 3) && ($urandom_range(0, 99) < 60);
                we[m] = 1'($urandom_range(0, 1));
                lk[m] = $urandom_range(0, 99) < 20;
                a[m]  = 11'h7F0 | 11'($urandom_range(0, 15));
                d[m]  = 9'($urandom);
                drv(m, v[m], we[m], lk[m], a[m], d[m]);
            end
            @(negedge clk);
            if (m_lock != 0) eg = v[m_owner] ? m_owner : -1;
            else if (v[0] && v[1]) eg = 1 - m_last;
            else if (v[0]) eg = 0;
            else if (v[1]) eg = 1;
            else eg = -1;
            rdy("rnd", eg == 0, eg == 1);
            chk("rnd_ce", vram_ce, p_x);
            if (p_x) begin
                chk("rnd_addr", vram_addr, p_a);
                chk("rnd_wre", vram_wre, p_we);
                if (p_we) chk("rnd_din", vram_din, p_d);
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                r = q.pop_front();
                chk("rnd_rv0", m0_if.rvalid, r.id == 0);
                chk("rnd_rv1", m1_if.rvalid, r.id == 1);
                if (r.id == 0) chk("rnd_rd0", m0_if.rdata, r.data);
                else chk("rnd_rd1", m1_if.rdata, r.data);
            end else begin
                chk("rnd_rv0", m0_if.rvalid, 0);
                chk("rnd_rv1", m1_if.rvalid, 0);
            end
            p_x = eg >= 0;
            if (eg >= 0) begin
                m_last = eg;
                p_a = a[eg]; p_d = d[eg]; p_we = we[eg];
                if (we[eg]) mmem[a[eg][3:0]] = d[eg];
                else q.push_back('{cyc + 2, eg, mmem[a[eg][3:0]]});
            end
            if (m_lock != 0) begin
                m_held++;
                if (m_held == MAXL) begin
                    m_lock = 0;
                    m_last = m_owner;
                end else if (eg == m_owner && !lk[m_owner]) begin
                    m_lock = 0;
                end
            end else if (eg >= 0 && lk[eg]) begin
                m_lock = 1; m_owner = eg; m_held = 0;
            end
            cyc++;
            step();
        end
        chk("rd_lost", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
